// File: rtl/reg_ctrl_pkg.sv
// Shared types and default opcodes for the byte-command register controller.
package reg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ADDR  = 3'd1,
    WR_DATA  = 3'd2,
    RD_ADDR  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_WAIT  = 3'd5,
    TX_SEND  = 3'd6
  } state_e;

  localparam logic [7:0] DEF_CMD_WR = 8'hAA;
  localparam logic [7:0] DEF_CMD_RD = 8'hBB;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Decodes write/read byte frames into register file strobes; read data goes to TX after a 4-cycle minimum.
// Stalls in TX_SEND while TX_BUSY is high; bytes arriving during a read are dropped with CMD_ERR.
module reg_cmd_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int                  OP_WIDTH   = 8,
  parameter int                  ADDR       = 4,
  parameter logic [OP_WIDTH-1:0] CMD_WR     = OP_WIDTH'(DEF_CMD_WR),
  parameter logic [OP_WIDTH-1:0] CMD_RD     = OP_WIDTH'(DEF_CMD_RD),
  parameter int                  RD_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OP_WIDTH-1:0] RX_P_DATA,
  input  logic                RX_D_VLD,
  output logic                WrEn,
  output logic                RdEn,
  output logic [ADDR-1:0]     Address,
  output logic [OP_WIDTH-1:0] WrData,
  input  logic [OP_WIDTH-1:0] RdData,
  input  logic                RdData_VLD,
  output logic [OP_WIDTH-1:0] TX_P_DATA,
  output logic                TX_D_VLD,
  input  logic                TX_BUSY,
  output logic                CMD_ERR,
  output logic                BUSY
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR-1:0]     addr_q, addr_d;
  logic [OP_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [OP_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                tx_vld_q, tx_vld_d;
  logic                cmd_err_q, cmd_err_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_d = RD_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        // Strobe is registered, so it is raised here to be high throughout RD_ISSUE.
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          rd_en_d = 1'b1;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        cmd_err_d = RX_D_VLD;
        cnt_d     = '0;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        cmd_err_d = RX_D_VLD;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (RdData_VLD) begin
          tx_data_d = RdData;
          state_d   = TX_SEND;
        end else if (cnt_q == CNT_LAST) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      TX_SEND: begin
        cmd_err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
      busy_q    <= busy_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = cmd_err_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl with a small 16x8 register file model.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       WrEn, RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_VLD;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY;
  logic       CMD_ERR;
  logic       BUSY;

  int n_cmp = 0;
  int n_err = 0;
  int wr_pulses = 0, rd_pulses = 0, tx_pulses = 0, overlap = 0;
  logic rf_respond = 1'b1;
  logic [7:0] mem [16] = '{2: 8'h81, default: 8'h00};

  always #5 CLK = ~CLK;

  reg_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_VLD(RdData_VLD), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  // Register file model: data valid one cycle after the read strobe.
  always @(posedge CLK) begin
    RdData_VLD <= RdEn && rf_respond;
    RdData     <= mem[Address];
    if (WrEn) mem[Address] <= WrData;
  end

  always @(negedge CLK) begin
    if (WrEn) wr_pulses++;
    if (RdEn) rd_pulses++;
    if (TX_D_VLD) tx_pulses++;
    if (WrEn && RdEn) overlap++;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick();
    tick();
    n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", WrEn); end
    n_cmp++; if (RdEn !== 1'b0) begin n_err++; $display("FAIL reset_rden: got %b want 0", RdEn); end
    n_cmp++; if (Address !== 4'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", Address); end
    n_cmp++; if (TX_D_VLD !== 1'b0) begin n_err++; $display("FAIL reset_txvld: got %b want 0", TX_D_VLD); end
    n_cmp++; if (TX_P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_txdata: got %h want 00", TX_P_DATA); end
    n_cmp++; if (CMD_ERR !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", CMD_ERR); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_write;
    int wr0;
    wr0 = wr_pulses;
    send_byte(8'hAA);
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL wr_busy_hi: got %b want 1", BUSY); end
    send_byte(8'h05);
    send_byte(8'h3C);
    n_cmp++; if (WrEn !== 1'b1) begin n_err++; $display("FAIL wr_en: got %b want 1", WrEn); end
    n_cmp++; if (Address !== 4'h5) begin n_err++; $display("FAIL wr_addr: got %h want 5", Address); end
    n_cmp++; if (WrData !== 8'h3C) begin n_err++; $display("FAIL wr_data: got %h want 3c", WrData); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL wr_busy_lo: got %b want 0", BUSY); end
    tick();
    n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL wr_en_off: got %b want 0", WrEn); end
    n_cmp++; if (wr_pulses - wr0 != 1) begin n_err++; $display("FAIL wr_pulse_cnt: got %0d want 1", wr_pulses - wr0); end
  endtask

  task automatic test_read;
    int rd0;
    rd0 = rd_pulses;
    send_byte(8'hBB);
    send_byte(8'h02);
    n_cmp++; if (RdEn !== 1'b1) begin n_err++; $display("FAIL rd_en: got %b want 1", RdEn); end
    n_cmp++; if (Address !== 4'h2) begin n_err++; $display("FAIL rd_addr: got %h want 2", Address); end
    n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL rd_no_wren: got %b want 0", WrEn); end
    tick();
    n_cmp++; if (RdEn !== 1'b0) begin n_err++; $display("FAIL rd_en_off: got %b want 0", RdEn); end
    tick();
    n_cmp++; if (TX_D_VLD !== 1'b0) begin n_err++; $display("FAIL rd_tx_early: got %b want 0", TX_D_VLD); end
    tick();
    n_cmp++; if (TX_D_VLD !== 1'b1) begin n_err++; $display("FAIL rd_tx_vld: got %b want 1", TX_D_VLD); end
    n_cmp++; if (TX_P_DATA !== 8'h81) begin n_err++; $display("FAIL rd_tx_data: got %h want 81", TX_P_DATA); end
    tick();
    n_cmp++; if (TX_D_VLD !== 1'b0) begin n_err++; $display("FAIL rd_tx_off: got %b want 0", TX_D_VLD); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rd_busy_lo: got %b want 0", BUSY); end
    n_cmp++; if (rd_pulses - rd0 != 1) begin n_err++; $display("FAIL rd_pulse_cnt: got %0d want 1", rd_pulses - rd0); end
  endtask

  task automatic test_tx_busy;
    TX_BUSY = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h05);
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++; if (TX_D_VLD !== 1'b0) begin n_err++; $display("FAIL busy_tx_held_%0d: got %b want 0", i, TX_D_VLD); end
      if (i >= 2) begin
        n_cmp++; if (TX_P_DATA !== 8'h3C) begin n_err++; $display("FAIL busy_data_%0d: got %h want 3c", i, TX_P_DATA); end
      end
    end
    TX_BUSY = 1'b0;
    send_byte(8'h12);
    n_cmp++; if (TX_D_VLD !== 1'b1) begin n_err++; $display("FAIL busy_tx_vld: got %b want 1", TX_D_VLD); end
    n_cmp++; if (CMD_ERR !== 1'b1) begin n_err++; $display("FAIL busy_drop_err: got %b want 1", CMD_ERR); end
    n_cmp++; if (TX_P_DATA !== 8'h3C) begin n_err++; $display("FAIL busy_tx_data: got %h want 3c", TX_P_DATA); end
    tick();
    n_cmp++; if (TX_D_VLD !== 1'b0) begin n_err++; $display("FAIL busy_tx_off: got %b want 0", TX_D_VLD); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_err_idle;
    send_byte(8'h55);
    n_cmp++; if (CMD_ERR !== 1'b1) begin n_err++; $display("FAIL idle_err: got %b want 1", CMD_ERR); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL idle_err_busy: got %b want 0", BUSY); end
    tick();
    n_cmp++; if (CMD_ERR !== 1'b0) begin n_err++; $display("FAIL idle_err_off: got %b want 0", CMD_ERR); end
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hFF);
    n_cmp++; if (WrEn !== 1'b1) begin n_err++; $display("FAIL after_err_wren: got %b want 1", WrEn); end
    n_cmp++; if (Address !== 4'h1) begin n_err++; $display("FAIL after_err_addr: got %h want 1", Address); end
    n_cmp++; if (WrData !== 8'hFF) begin n_err++; $display("FAIL after_err_data: got %h want ff", WrData); end
    tick();
  endtask

  task automatic test_timeout;
    int tx0;
    tx0 = tx_pulses;
    rf_respond = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h03);
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_cmp++; if (CMD_ERR !== 1'b0) begin n_err++; $display("FAIL to_early_err_%0d: got %b want 0", i, CMD_ERR); end
    end
    tick();
    n_cmp++; if (CMD_ERR !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", CMD_ERR); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL to_idle: got %b want 0", BUSY); end
    tick();
    tick();
    n_cmp++; if (CMD_ERR !== 1'b0) begin n_err++; $display("FAIL to_err_off: got %b want 0", CMD_ERR); end
    n_cmp++; if (tx_pulses != tx0) begin n_err++; $display("FAIL to_no_tx: got %0d want %0d", tx_pulses, tx0); end
    rf_respond = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int wr0;
    wr0 = wr_pulses;
    send_byte(8'hAA);
    send_byte(8'h05);
    RX_P_DATA = 8'hAA;
    RX_D_VLD  = 1'b1;
    RST       = 1'b1;
    tick();
    RST       = 1'b0;
    RX_D_VLD  = 1'b0;
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", BUSY); end
    n_cmp++; if (Address !== 4'h0) begin n_err++; $display("FAIL mid_rst_addr: got %h want 0", Address); end
    send_byte(8'h3C);
    n_cmp++; if (CMD_ERR !== 1'b1) begin n_err++; $display("FAIL mid_rst_err: got %b want 1", CMD_ERR); end
    n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL mid_rst_nowr: got %b want 0", WrEn); end
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h5A);
    n_cmp++; if (WrEn !== 1'b1) begin n_err++; $display("FAIL mid_rst_wren: got %b want 1", WrEn); end
    n_cmp++; if (Address !== 4'h7) begin n_err++; $display("FAIL mid_rst_waddr: got %h want 7", Address); end
    n_cmp++; if (WrData !== 8'h5A) begin n_err++; $display("FAIL mid_rst_wdata: got %h want 5a", WrData); end
    tick();
    n_cmp++; if (wr_pulses - wr0 != 1) begin n_err++; $display("FAIL mid_rst_wr_cnt: got %0d want 1", wr_pulses - wr0); end
  endtask

  task automatic test_no_overlap;
    n_cmp++; if (overlap != 0) begin n_err++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    RST       = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    TX_BUSY   = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_tx_busy();
    test_err_idle();
    test_timeout();
    test_reset_midframe();
    test_no_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

Byte-command controller that sequences the 16×8 register file from the serial receive path. It decodes write and read frames arriving as parallel bytes, drives the register file's write/read strobes, and forwards read results to the transmit path under a busy handshake. It sits between the UART RX/TX byte interfaces and the register file in the processing system.

## Interface
- OP_WIDTH, 8, data/byte width
- ADDR, 4, register file address width
- CMD_WR, 8'hAA, write-command opcode
- CMD_RD, 8'hBB, read-command opcode
- RD_TIMEOUT, 15, max cycles to wait for RdData_VLD after a read strobe
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- RX_P_DATA  in  OP_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- WrEn  out  1  register file write strobe
- RdEn  out  1  register file read strobe
- Address  out  ADDR  register file address
- WrData  out  OP_WIDTH  register file write data
- RdData  in  OP_WIDTH  register file read data
- RdData_VLD  in  1  register file read data valid
- TX_P_DATA  out  OP_WIDTH  byte to transmit
- TX_D_VLD  out  1  one-cycle pulse, TX_P_DATA valid
- TX_BUSY  in  1  transmitter cannot accept a byte
- CMD_ERR  out  1  one-cycle pulse on protocol error
- BUSY  out  1  high in every state except IDLE

## Operation
- Frames: write = CMD_WR, addr, data; read = CMD_RD, addr. Address byte truncated to its low ADDR bits.
- All outputs are registered. Reset value of every output is 0; reset overrides everything, including mid-frame and mid-transmit. State returns to IDLE, and partial frames are discarded.
- States:
  - IDLE:
    - byte == CMD_WR → WR_ADDR
    - byte == CMD_RD → RD_ADDR
    - any other byte → CMD_ERR pulse, stay in IDLE
  - WR_ADDR: on byte, latch Address → WR_DATA.
  - WR_DATA: on byte, WrData = byte, WrEn = 1 for exactly one cycle → IDLE.
  - RD_ADDR: on byte, latch Address → RD_ISSUE.
  - RD_ISSUE: RdEn = 1 for exactly one cycle. Clear timeout counter → RD_WAIT.
  - RD_WAIT:
    - RdData_VLD → capture RdData into TX_P_DATA → TX_SEND
    - counter reaches RD_TIMEOUT → CMD_ERR pulse → IDLE
  - TX_SEND: when TX_BUSY is low, TX_D_VLD = 1 for one cycle → IDLE. TX_P_DATA is held stable from capture until TX_D_VLD has fired.
- RX_D_VLD in RD_ISSUE, RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulse, state unaffected.
- WrEn and RdEn are never high together. Address and WrData remain stable while their strobe is high.
- No frame-level timeout between bytes: the controller waits indefinitely in WR_ADDR, WR_DATA and RD_ADDR.

## Timing
- Last write byte sampled at edge k → WrEn high during cycle k..k+1 (one cycle).
- Read address sampled at edge k → RdEn high k..k+1. Register file returns RdData_VLD after edge k+1.
- Captured at edge k+2 → TX_D_VLD high k+3..k+4 when TX_BUSY is low. Minimum read latency is 4 cycles from the address byte to the TX pulse.
- TX_BUSY is sampled each cycle in TX_SEND. Each busy cycle adds one cycle of latency.
- RX_D_VLD and RST in the same cycle: reset wins, and the byte is lost.
- CMD_ERR and TX_D_VLD can pulse in the same cycle (dropped byte during TX_SEND).
- Timeout counter is ceil(log2(RD_TIMEOUT+1)) bits and saturates. It counts cycles in RD_WAIT only.

## Structure
- Shared package reg_ctrl_pkg:
  - state enum (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_ISSUE, RD_WAIT, TX_SEND)
  - default opcode constants (CMD_WR, CMD_RD)
- Single module: FSM plus data/address holding registers and the timeout counter. No sub-module is warranted.

## Test plan
- Reset, then send AA, 05, 3C → exactly one WrEn pulse with Address=5, WrData=0x3C. BUSY falls the next cycle.
- Send BB, 02 with a register file model holding 0x81 at address 2 → one RdEn with Address=2, then TX_D_VLD with TX_P_DATA=0x81, 4 cycles after the address byte.
- Read with TX_BUSY held high for 10 cycles → TX_D_VLD delayed until the cycle after TX_BUSY falls; TX_P_DATA held stable throughout.
- Send 0x55 in IDLE → one CMD_ERR pulse, state stays IDLE. A following AA, 01, FF still writes 0xFF to address 1.
- Read with RdData_VLD never asserted → CMD_ERR 15 cycles after entering RD_WAIT, no TX_D_VLD, return to IDLE.
- Send AA, 05, assert RST for one cycle, then send 3C → no WrEn; 3C raises CMD_ERR; the next full AA frame writes correctly.
